// File: rtl/stream_pkg.sv
// stream_pkg: shared types and width ceilings for the DRAM stream arbiter
package stream_pkg;
  localparam int DEF_NUM_PE = 4;
  localparam int MAX_LEN_W = 8;
  localparam int MAX_ADDR_W = 16;
  typedef enum logic [1:0] {IDLE, CMD, STREAM, FINISH} stream_state_e;
  typedef struct packed {
    logic                  is_filter;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_LEN_W-1:0]  len;
  } stream_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from last+1 with wrap
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] id,
  output logic          any_valid
);
  logic [IW-1:0] k;
  always_comb begin
    grant = '0;
    id = '0;
    any_valid = 1'b0;
    k = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(last) + i) % N);
      if (!any_valid && req[k]) begin
        grant[k] = 1'b1;
        id = k;
        any_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin sharing of one DRAM stream port among NUM_PE PEs.
// Define STREAM_FILTER_PRIORITY_EN to favour filter requesters during selection.
module stream_arbiter
  import stream_pkg::*;
#(
  parameter int NUM_PE = DEF_NUM_PE,
  parameter int DATA_W = 16,
  parameter int IDX_W = 4,
  parameter int LEN_W = MAX_LEN_W,
  parameter int ADDR_W = MAX_ADDR_W,
  localparam int GW = NUM_PE > 1 ? $clog2(NUM_PE) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PE-1:0]        pe_req_valid,
  input  logic [NUM_PE-1:0]        pe_req_type,
  input  logic [NUM_PE*ADDR_W-1:0] pe_req_addr,
  input  logic [NUM_PE*LEN_W-1:0]  pe_req_len,
  output logic [NUM_PE-1:0]        pe_req_ready,
  output logic                     dram_cmd_valid,
  input  logic                     dram_cmd_ready,
  output logic [ADDR_W-1:0]        dram_cmd_addr,
  output logic [LEN_W-1:0]         dram_cmd_len,
  input  logic                     dram_rsp_valid,
  input  logic [DATA_W-1:0]        dram_rsp_data,
  input  logic [IDX_W-1:0]         dram_rsp_idx,
  output logic [NUM_PE-1:0]        pe_data_valid,
  output logic [DATA_W-1:0]        pe_data,
  output logic [IDX_W-1:0]         pe_idx,
  output logic [NUM_PE-1:0]        stream_filter_finish,
  output logic [NUM_PE-1:0]        stream_input_finish,
  output logic                     busy,
  output logic [GW-1:0]            cur_grant
);
  stream_state_e state;
  stream_req_t req;
  logic [LEN_W-1:0] cnt;
  logic [1:0] fin_cnt;
  logic [GW-1:0] last_grant, gid;
  logic [NUM_PE-1:0] mask, grant;
  logic any;
  logic [LEN_W-1:0] sel_len;
`ifdef STREAM_FILTER_PRIORITY_EN
  assign mask = |(pe_req_valid & pe_req_type) ? pe_req_valid & pe_req_type : pe_req_valid;
`else
  assign mask = pe_req_valid;
`endif
  rr_arbiter #(.N(NUM_PE)) u_rr (
    .req(mask),
    .last(last_grant),
    .grant(grant),
    .id(gid),
    .any_valid(any)
  );
  assign sel_len = pe_req_len[gid*LEN_W +: LEN_W];
  assign dram_cmd_addr = ADDR_W'(req.addr);
  assign dram_cmd_len = LEN_W'(req.len);
  assign busy = state != IDLE;
  // fin_cnt paces FINISH: a zero-length burst enters at 0, a streamed one at 1;
  // the pulse is launched at 1 and the arbiter re-opens after 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req <= '0;
      cnt <= '0;
      fin_cnt <= '0;
      last_grant <= GW'(NUM_PE - 1);
      cur_grant <= '0;
      pe_req_ready <= '0;
      dram_cmd_valid <= 1'b0;
      pe_data_valid <= '0;
      pe_data <= '0;
      pe_idx <= '0;
      stream_filter_finish <= '0;
      stream_input_finish <= '0;
    end else begin
      pe_req_ready <= '0;
      pe_data_valid <= '0;
      stream_filter_finish <= '0;
      stream_input_finish <= '0;
      case (state)
        IDLE: if (any) begin
          cur_grant <= gid;
          pe_req_ready <= grant;
          req <= '{is_filter: pe_req_type[gid],
                   addr: MAX_ADDR_W'(pe_req_addr[gid*ADDR_W +: ADDR_W]),
                   len: MAX_LEN_W'(sel_len)};
          fin_cnt <= '0;
          state <= sel_len == '0 ? FINISH : CMD;
          dram_cmd_valid <= sel_len != '0;
        end
        CMD: if (dram_cmd_ready) begin
          dram_cmd_valid <= 1'b0;
          cnt <= '0;
          state <= STREAM;
        end
        STREAM: if (dram_rsp_valid) begin
          pe_data_valid <= NUM_PE'(1) << cur_grant;
          pe_data <= dram_rsp_data;
          pe_idx <= dram_rsp_idx;
          cnt <= cnt + LEN_W'(1);
          if (cnt == dram_cmd_len - LEN_W'(1)) begin
            state <= FINISH;
            fin_cnt <= 2'd1;
          end
        end
        FINISH: begin
          fin_cnt <= fin_cnt + 2'd1;
          stream_filter_finish <= fin_cnt == 2'd1 && req.is_filter ? NUM_PE'(1) << cur_grant : '0;
          stream_input_finish <= fin_cnt == 2'd1 && !req.is_filter ? NUM_PE'(1) << cur_grant : '0;
          if (fin_cnt == 2'd2) begin
            last_grant <= cur_grant;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: randomized bench with a transaction-level reference model for stream_arbiter
module tb_stream_arbiter;
  localparam int N = 4, DW = 16, IW = 4, LW = 8, AW = 16;
  logic clk = 0, rst = 1;
  logic [N-1:0] pe_req_valid = '0, pe_req_type = '0;
  logic [N*AW-1:0] pe_req_addr = '0;
  logic [N*LW-1:0] pe_req_len = '0;
  logic [N-1:0] pe_req_ready, pe_data_valid, stream_filter_finish, stream_input_finish;
  logic dram_cmd_valid, busy;
  logic dram_cmd_ready = 0, dram_rsp_valid = 0;
  logic [AW-1:0] dram_cmd_addr;
  logic [LW-1:0] dram_cmd_len;
  logic [DW-1:0] dram_rsp_data = '0, pe_data;
  logic [IW-1:0] dram_rsp_idx = '0, pe_idx;
  logic [1:0] cur_grant;

  stream_arbiter dut (
    .clk(clk), .rst(rst),
    .pe_req_valid(pe_req_valid), .pe_req_type(pe_req_type),
    .pe_req_addr(pe_req_addr), .pe_req_len(pe_req_len), .pe_req_ready(pe_req_ready),
    .dram_cmd_valid(dram_cmd_valid), .dram_cmd_ready(dram_cmd_ready),
    .dram_cmd_addr(dram_cmd_addr), .dram_cmd_len(dram_cmd_len),
    .dram_rsp_valid(dram_rsp_valid), .dram_rsp_data(dram_rsp_data), .dram_rsp_idx(dram_rsp_idx),
    .pe_data_valid(pe_data_valid), .pe_data(pe_data), .pe_idx(pe_idx),
    .stream_filter_finish(stream_filter_finish), .stream_input_finish(stream_input_finish),
    .busy(busy), .cur_grant(cur_grant)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [N-1:0] pend = '0, typ = '0, drv_pend = '0, drv_typ = '0;
  int adr[N], len[N];
  int cyc = 0, last = N - 1, g = 0, L = 0, a = 0, cnt = 0, fin_due = -1, last_fin = -10, idle_wait = 0;
  bit act = 0, gtyp = 0, accepted = 0, hs = 0, beat_pend = 0, exp_cv = 0, seq = 0, rnd_req = 0;
  int ready_mode = 0, rsp_mode = 0;
  logic [DW-1:0] bdata;
  logic [IW-1:0] bidx;
  int grants[$];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(int i);
    return N'(1) << i;
  endfunction

  // first pending requester after the previous winner, filters first when prioritised
  function automatic int rr_pick(logic [N-1:0] v, logic [N-1:0] t, int lst);
    logic [N-1:0] m = v;
`ifdef STREAM_FILTER_PRIORITY_EN
    if (|(v & t)) m = v & t;
`endif
    for (int i = 1; i <= N; i++) if (m[(lst + i) % N]) return (lst + i) % N;
    return -1;
  endfunction

  task automatic rq(int i, bit t, int ad, int ln);
    pend[i] = 1; typ[i] = t; adr[i] = ad; len[i] = ln;
  endtask

  task automatic step();
    int p;
    bit rdy, rv;
    logic [DW-1:0] dat;
    logic [IW-1:0] ix;
    @(negedge clk);
    cyc++;
    if (rst) begin
      check("rst_outs", {pe_req_ready, dram_cmd_valid, dram_cmd_addr, dram_cmd_len, pe_data_valid,
                         pe_data, pe_idx, stream_filter_finish, stream_input_finish, busy, cur_grant}, 0);
      act = 0; pend = '0; last = N - 1; last_fin = -10; fin_due = -1;
      beat_pend = 0; hs = 0; accepted = 0; exp_cv = 0; idle_wait = 0;
    end else begin
      if (hs) accepted = 1;
      check("dvalid", pe_data_valid, beat_pend ? oh(g) : '0);
      if (beat_pend) begin
        check("data", pe_data, bdata);
        check("idx", pe_idx, bidx);
      end
      check("filt_fin", stream_filter_finish, (cyc == fin_due && gtyp) ? oh(g) : '0);
      check("in_fin", stream_input_finish, (cyc == fin_due && !gtyp) ? oh(g) : '0);
      if (|pe_req_ready) begin
        p = rr_pick(drv_pend, drv_typ, last);
        check("ready", pe_req_ready, p < 0 ? '0 : oh(p));
        check("ready_early", (act || cyc < last_fin + 2) ? 1 : 0, 0);
        if (p >= 0 && !act) begin
          act = 1; g = p; gtyp = typ[p]; a = adr[p]; L = len[p];
          pend[p] = 0; accepted = 0; cnt = 0; hs = 0;
          grants.push_back(p);
          if (L == 0) fin_due = cyc + 2;
          check("cur_grant", cur_grant, p);
        end
        idle_wait = 0;
      end else if (!act && |drv_pend) begin
        if (++idle_wait > 8) begin
          check("ready_timeout", 1, 0);
          idle_wait = 0;
        end
      end else idle_wait = 0;
      exp_cv = act && L > 0 && !accepted;
      check("cmd_valid", dram_cmd_valid, exp_cv);
      if (exp_cv) begin
        check("cmd_addr", dram_cmd_addr, a);
        check("cmd_len", dram_cmd_len, L);
      end
      if (cyc != fin_due) check("busy", busy, act);
      if (cyc == fin_due) begin
        act = 0; last = g; last_fin = cyc; fin_due = -1;
      end
    end
    rdy = ready_mode == 0 ? 1'($urandom % 2) : ready_mode == 2;
    hs = exp_cv && rdy;
    rv = rsp_mode == 1 ? 1 : rsp_mode == 2 ? 0 : ($urandom % 4 != 0);
    dat = DW'($urandom);
    ix = IW'($urandom);
    if (rv && act && accepted && cnt < L) begin
      if (seq) dat = DW'(17 * (cnt + 1));
      beat_pend = 1; bdata = dat; bidx = ix; cnt++;
      if (cnt == L) fin_due = cyc + 2;
    end else beat_pend = 0;
    if (rnd_req)
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom % 8 == 0) rq(i, 1'($urandom % 2), int'($urandom % 65536), int'($urandom % 6));
    for (int i = 0; i < N; i++) begin
      pe_req_valid[i] = pend[i];
      pe_req_type[i] = typ[i];
      pe_req_addr[i*AW +: AW] = AW'(adr[i]);
      pe_req_len[i*LW +: LW] = LW'(len[i]);
    end
    drv_pend = pend; drv_typ = typ;
    dram_cmd_ready = rdy; dram_rsp_valid = rv; dram_rsp_data = dat; dram_rsp_idx = ix;
  endtask

  task automatic run_until_idle(int lim);
    int k = 0;
    do begin step(); k++; end while ((act || |pend) && k < lim);
    if (act || |pend) check("idle_timeout", 1, 0);
  endtask

  task automatic pulse_rst();
    rst = 1; step(); rst = 0;
  endtask

  initial begin
    int b, k;
    for (int i = 0; i < N; i++) begin adr[i] = 0; len[i] = 0; end
    step(); step(); rst = 0;
    // PE1 filter burst with known beat values
    seq = 1; rq(1, 1, 'h40, 3); run_until_idle(60); seq = 0;
    check("s1_grant", grants.size() > 0 ? grants[$] : -1, 1);
    step();
    // all PEs request input bursts after reset, then PE0 again
    pulse_rst();
    b = grants.size();
    for (int i = 0; i < N; i++) rq(i, 0, 'h100 + i, 2);
    run_until_idle(200);
    rq(0, 0, 'h200, 2); run_until_idle(60);
    for (int i = 0; i < 5; i++) check("s2_order", grants.size() > b + i ? grants[b + i] : -1, i % 4);
    // zero-length burst never issues a command
    rq(3, 0, 'h300, 0); run_until_idle(30);
    check("s3_grant", grants.size() > 0 ? grants[$] : -1, 3);
    // command stall with stray response beats
    ready_mode = 1; rsp_mode = 1; rq(1, 0, 'h123, 4);
    k = 0; while (!act && k < 20) begin step(); k++; end
    check("s4_started", act, 1);
    repeat (5) step();
    ready_mode = 0; rsp_mode = 0; run_until_idle(100);
    // reset in mid-burst abandons it
    ready_mode = 2; rq(1, 1, 'h500, 4);
    k = 0; while (!(act && cnt == 2) && k < 60) begin step(); k++; end
    check("s5_two_beats", cnt, 2);
    rsp_mode = 2; step(); pulse_rst();
    rsp_mode = 0; ready_mode = 0;
    b = grants.size();
    rq(2, 0, 'h600, 2); rq(0, 0, 'h700, 3); run_until_idle(100);
    check("s5_first", grants.size() > b ? grants[b] : -1, 0);
    check("s5_second", grants.size() > b + 1 ? grants[b + 1] : -1, 2);
    // input vs filter contention
    b = grants.size();
    rq(0, 0, 'h10, 2); rq(2, 1, 'h20, 2); run_until_idle(100);
`ifdef STREAM_FILTER_PRIORITY_EN
    check("s6_first", grants.size() > b ? grants[b] : -1, 2);
`else
    check("s6_first", grants.size() > b ? grants[b] : -1, 0);
`endif
    // maximum length burst
    ready_mode = 2; rsp_mode = 1; rq(1, 1, 'hFFFF, 255); run_until_idle(400);
    ready_mode = 0; rsp_mode = 0;
    // random traffic
    rnd_req = 1; repeat (2000) step();
    rnd_req = 0; run_until_idle(600);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- Shares the single DRAM stream port among NUM_PE sparse-CNN PEs.
- Each PE requests a burst of compressed weights (filter) or compressed activations (input). The block grants requesters round-robin, issues one DRAM command, and routes the returned (data, indices) beats to the granted PE.
- At the end of each burst it pulses that PE's stream_filter_finish or stream_input_finish.
- Sits between the PE array and the DRAM model/top.

Parameters:
- NUM_PE, 4, number of requesting PEs
- DATA_W, 16, compressed data word width (signed)
- IDX_W, 4, width of the indices field
- LEN_W, 8, burst length width, in compressed entries
- ADDR_W, 16, DRAM word address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pe_req_valid  in  NUM_PE  per-PE request; held until its pe_req_ready pulse
- pe_req_type  in  NUM_PE  per-PE type: 1 = filter, 0 = input
- pe_req_addr  in  NUM_PE*ADDR_W  per-PE burst start address
- pe_req_len  in  NUM_PE*LEN_W  per-PE burst length
- pe_req_ready  out  NUM_PE  one-hot, one-cycle acceptance pulse
- dram_cmd_valid  out  1  command valid
- dram_cmd_ready  in  1  command accepted
- dram_cmd_addr  out  ADDR_W  latched address
- dram_cmd_len  out  LEN_W  latched length
- dram_rsp_valid  in  1  response beat valid
- dram_rsp_data  in  DATA_W  response data
- dram_rsp_idx  in  IDX_W  response indices
- pe_data_valid  out  NUM_PE  one-hot beat strobe to the granted PE
- pe_data  out  DATA_W  broadcast data
- pe_idx  out  IDX_W  broadcast indices
- stream_filter_finish  out  NUM_PE  one-cycle pulse, filter burst complete
- stream_input_finish  out  NUM_PE  one-cycle pulse, input burst complete
- busy  out  1  high whenever state is not IDLE
- cur_grant  out  $clog2(NUM_PE)  granted PE id; holds its last value when idle

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0, last_grant = NUM_PE-1 so PE0 has first priority.
- States: IDLE, CMD, STREAM, FINISH.
- IDLE:
  - If any pe_req_valid, select the first valid requester scanning from last_grant+1 with wrap-around.
  - Latch id, type, addr, len, and pulse pe_req_ready[id] in the cycle after selection.
  - Next state is CMD; if len == 0, go straight to FINISH with no command issued.
  - Requests are sampled only in IDLE. Deassertion before ready is illegal; a requester that deasserts is simply skipped.
- CMD:
  - dram_cmd_valid = 1, with addr and len stable, until sampled with dram_cmd_ready.
  - Then go to STREAM and clear the beat counter.
- STREAM:
  - Each dram_rsp_valid beat is registered: pe_data_valid[id], pe_data and pe_idx appear 1 cycle later.
  - The counter increments per beat. The beat accepted with counter == len-1 moves the FSM to FINISH.
  - No backpressure: PEs must accept one beat per cycle.
- dram_rsp_valid in IDLE, CMD or FINISH is dropped and has no effect.
- FINISH:
  - Registered pulse on stream_filter_finish[id] (type 1) or stream_input_finish[id] (type 0).
  - The pulse appears exactly one cycle after the last pe_data_valid, or two cycles after pe_req_ready when len == 0.
  - last_grant <= id; return to IDLE.
  - Back-to-back bursts: the next pe_req_ready comes no earlier than 2 cycles after the finish pulse.
- Counter is LEN_W bits; len = 2^LEN_W-1 is the maximum and the counter never wraps.
- rst mid-burst: the burst is abandoned with no finish pulse, outputs clear on the next edge, and the requester must re-request.

Optional Feature:
- Macro STREAM_FILTER_PRIORITY_EN, affecting IDLE selection only.
- Defined: if any valid request has type == 1, round-robin runs over filter requesters only; otherwise over all requesters.
- Undefined: pure round-robin; pe_req_type only selects which finish output pulses.

Decomposition:
- Shared package stream_pkg:
  - stream_req_t struct {type, addr, len}
  - stream_state_e enum
  - NUM_PE/LEN_W defaults alongside the existing `max_* defines
- Sub-module rr_arbiter(N): combinational; inputs request mask and last pointer; outputs one-hot grant, grant id and any_valid. It is reused by the priority option via a masked request vector.

Test Plan:
- PE1 filter, addr 0x40, len 3 → pe_req_ready = 0010 once; cmd addr 0x40 / len 3; 3 beats (0x0011, 0x0022, 0x0033) on pe_data_valid = 0010; stream_filter_finish[1] one cycle after the third beat; busy low afterwards.
- All 4 PEs request input bursts of len 2 right after reset → grants 0, 1, 2, 3, then 0 again on re-request; stream_input_finish pulses in the same order.
- PE3 len 0 → pe_req_ready[3], dram_cmd_valid never high, stream_input_finish[3] two cycles after the ready pulse.
- dram_cmd_ready low for 5 cycles, with stray dram_rsp_valid beats during CMD → cmd_valid/addr/len stay stable, stray beats are not forwarded, and the burst of 4 completes normally.
- rst pulsed after 2 of 4 beats → all outputs 0 next cycle and no finish pulse; re-request from PE2 and PE0 grants PE0 first.
- PE0 input and PE2 filter requesting simultaneously → with STREAM_FILTER_PRIORITY_EN, PE2 is granted first; without it, PE0 is granted first.
